// File: rtl/alu_seq.sv
// alu_seq: clocked signed ALU. Add/sub complete in one cycle; multiply
// (shift-add on magnitudes) and divide (restoring on magnitudes) iterate
// one bit per cycle over WIDTH cycles. Results and flags are registered
// and change only on completion; the high word carries the product upper
// half or the remainder.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             error,
    output logic             ovf,
    output logic             neg,
    output logic             zero
);

    localparam logic [OPW-1:0]   OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0]   OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0]   OP_MUL  = OPW'(4);
    localparam logic [OPW-1:0]   OP_DIV  = OPW'(5);
    localparam int               CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    // Everything that is published on completion, loaded as one unit.
    typedef struct packed {
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic             err;
        logic             ovf;
        logic             neg;
        logic             zero;
    } res_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [OPW-1:0]   opc_q;
    logic [WIDTH-1:0] a_q, b_q;      // raw accepted operands (signs, special cases)
    logic [WIDTH-1:0] acc_q;         // mul: partial product high / div: partial remainder
    logic [WIDTH-1:0] lo_q;          // mul: multiplier -> product low / div: dividend -> quotient
    logic [WIDTH-1:0] m_q;           // mul: multiplicand magnitude / div: divisor magnitude
    logic [WIDTH-1:0] acc_nx, lo_nx;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_sh;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod_mag, prod;
    logic [WIDTH-1:0] quo, rem;
    res_t             res_q, res_d, iter_res;
    logic             accept, load_res;

    function automatic logic is_iter(input logic [OPW-1:0] opc);
        return (opc == OP_MUL) || (opc == OP_DIV);
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    // Single-cycle operations: add, sub, and the illegal-opcode result.
    function automatic res_t fast_res(input logic [OPW-1:0] opc,
                                      input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
        res_t r;
        r = '0;
        case (opc)
            OP_ADD: begin
                r.lo  = a + b;
                r.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r.lo[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                r.lo  = a - b;
                r.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r.lo[WIDTH-1] != a[WIDTH-1]);
            end
            default: r.err = 1'b1;
        endcase
        r.neg  = r.lo[WIDTH-1];
        r.zero = (r.lo == '0);
        return r;
    endfunction

    assign accept = start && (state_q != RUN);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; an add/sub accepted during FIN takes one RUN cycle so done can drop.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE, FIN: begin
                if (accept) begin
                    if (is_iter(opcode) || state_q == FIN) state_d = RUN;
                    else                                    state_d = FIN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (!is_iter(opc_q) || cnt_q == LAST) state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state and the registered result.
    always_comb begin
        busy  = (state_q == RUN);
        done  = (state_q == FIN);
        out   = res_q.lo;
        hi    = res_q.hi;
        error = res_q.err;
        ovf   = res_q.ovf;
        neg   = res_q.neg;
        zero  = res_q.zero;
    end

    // One iteration step: shift-add for mul, restoring subtract for div.
    always_comb begin
        mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_sh  = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
        div_ge  = (div_sh >= m_q);
        if (opc_q == OP_MUL) begin
            acc_nx = mul_sum[WIDTH:1];
            lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            acc_nx = div_ge ? div_sh - m_q : div_sh;
            lo_nx  = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Final sign fix-up and flags for the iterative ops, taken from the last step.
    always_comb begin
        prod_mag = {acc_nx, lo_nx};
        prod     = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -prod_mag : prod_mag;
        quo      = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -lo_nx : lo_nx;
        rem      = a_q[WIDTH-1] ? -acc_nx : acc_nx;
        iter_res = '0;
        if (opc_q == OP_MUL) begin
            iter_res.lo   = prod[WIDTH-1:0];
            iter_res.hi   = prod[2*WIDTH-1:WIDTH];
            iter_res.ovf  = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
            iter_res.neg  = prod[2*WIDTH-1];
            iter_res.zero = (prod == '0);
        end else if (b_q == '0) begin
            // Divide by zero: the iteration ran for timing only and is discarded.
            iter_res.err  = 1'b1;
            iter_res.lo   = '1;
            iter_res.hi   = a_q;
            iter_res.neg  = 1'b1;
            iter_res.zero = 1'b0;
        end else begin
            iter_res.lo   = quo;
            iter_res.hi   = rem;
            iter_res.ovf  = (a_q == MIN_VAL) && (b_q == '1);
            iter_res.neg  = quo[WIDTH-1];
            iter_res.zero = (quo == '0);
        end
    end

    // Result selection: fresh inputs when finishing straight from IDLE, latched operands from RUN.
    always_comb begin
        res_d = res_q;
        if (state_q == RUN) res_d = is_iter(opc_q) ? iter_res : fast_res(opc_q, a_q, b_q);
        else                res_d = fast_res(opcode, op1, op2);
    end

    assign load_res = (state_d == FIN);

    // Operand capture, iteration registers and the published result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            opc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
                opc_q <= opcode;
                a_q   <= op1;
                b_q   <= op2;
                acc_q <= '0;
                lo_q  <= (opcode == OP_MUL) ? mag(op2) : mag(op1);
                m_q   <= (opcode == OP_MUL) ? mag(op1) : mag(op2);
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + CW'(1);
                acc_q <= acc_nx;
                lo_q  <= lo_nx;
            end
            if (load_res) res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations plus random
// traffic checked every cycle against a signed-arithmetic reference model.
module tb_alu_seq;

    localparam int    W    = 16;
    localparam longint MAXV = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (W - 1));

    logic         clk = 1'b0;
    logic         rst, start;
    logic [3:0]   opcode;
    logic [W-1:0] op1, op2;
    logic         busy, done, error, ovf, neg, zero;
    logic [W-1:0] out, hi;

    alu_seq #(.WIDTH(W), .OPW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .op1(op1), .op2(op2), .busy(busy), .done(done),
        .out(out), .hi(hi), .error(error), .ovf(ovf), .neg(neg), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] o;
        logic [W-1:0] h;
        logic         err;
        logic         ovf;
        logic         neg;
        logic         zero;
    } res_t;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain signed arithmetic on wide integers.
    function automatic res_t model(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   r;
        longint sa, sb, v, rm;
        logic [2*W-1:0] pw;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v  = 0;
        rm = 0;
        r  = '0;
        case (opc)
            4'd0: begin v = sa + sb; r.o = v[W-1:0]; r.ovf = (v > MAXV) || (v < MINV); end
            4'd1: begin v = sa - sb; r.o = v[W-1:0]; r.ovf = (v > MAXV) || (v < MINV); end
            4'd4: begin
                v = sa * sb; pw = v[2*W-1:0];
                r.o = pw[W-1:0]; r.h = pw[2*W-1:W];
                r.ovf = (v > MAXV) || (v < MINV);
            end
            4'd5: begin
                if (sb == 0) begin
                    r.err = 1'b1; r.o = '1; r.h = a;
                end else begin
                    v = sa / sb; rm = sa % sb;
                    r.o = v[W-1:0]; r.h = rm[W-1:0];
                    r.ovf = (v > MAXV);
                end
            end
            default: r.err = 1'b1;
        endcase
        if (opc == 4'd4) begin
            r.neg = (v < 0); r.zero = (v == 0);
        end else begin
            r.neg = r.o[W-1]; r.zero = (r.o == '0);
        end
        return r;
    endfunction

    // Model timing: countdown to the completion edge; done marks the completion cycle.
    int   remaining = 0;
    logic exp_done  = 1'b0;
    res_t exp_res   = '0;
    res_t pend      = '0;

    always @(posedge clk) begin : model_p
        int   r_n;
        logic d_n;
        res_t e_n, p_n;
        r_n = remaining; d_n = 1'b0; e_n = exp_res; p_n = pend;
        if (rst) begin
            r_n = 0; e_n = '0;
        end else if (remaining > 0) begin
            r_n = remaining - 1;
            if (r_n == 0) begin d_n = 1'b1; e_n = pend; end
        end else if (start) begin
            p_n = model(opcode, op1, op2);
            if (opcode == 4'd4 || opcode == 4'd5) r_n = W;
            else if (exp_done)                    r_n = 1;
            else begin d_n = 1'b1; e_n = p_n; end
        end
        remaining <= r_n;
        exp_done  <= d_n;
        exp_res   <= e_n;
        pend      <= p_n;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, (remaining > 0));
            check("done", done, exp_done);
            check("result", {out, hi, error, ovf, neg, zero}, exp_res);
        end
    end

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return {1'b1, {(W-1){1'b0}}};
            4: return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rnd_opc();
        case ($urandom_range(0, 9))
            0, 1: return 4'd0;
            2, 3: return 4'd1;
            4, 5: return 4'd4;
            6, 7: return 4'd5;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    // Called at a negedge: issue one op, then wait (bounded) for done; lat counts cycles.
    task automatic run_op(input logic [3:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        opcode = opc; op1 = a; op2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opcode = 4'($urandom); op1 = W'($urandom); op2 = W'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_lit(input string name, input logic [3:0] opc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input res_t exp_v);
        int lat;
        @(negedge clk);
        run_op(opc, a, b, lat);
        check({name, "_lat"}, lat, exp_lat);
        check(name, {out, hi, error, ovf, neg, zero}, exp_v);
        check({name, "_model"}, model(opc, a, b), exp_v);
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b1; start = 1'b0; opcode = '0; op1 = '0; op2 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_state", {busy, done, out, hi, error, ovf, neg, zero}, '0);
        rst = 1'b0;

        do_lit("add_ovf",   4'd0, 16'h7FFF, 16'h0001, 1,  {16'h8000, 16'h0000, 4'b0110});
        do_lit("sub_zero",  4'd1, 16'h0005, 16'h0005, 1,  {16'h0000, 16'h0000, 4'b0001});
        do_lit("mul_neg",   4'd4, 16'hFFFD, 16'h0005, 17, {16'hFFF1, 16'hFFFF, 4'b0010});
        do_lit("mul_ovf",   4'd4, 16'h0100, 16'h0100, 17, {16'h0000, 16'h0001, 4'b0100});
        do_lit("div_neg",   4'd5, 16'hFFF9, 16'h0002, 17, {16'hFFFD, 16'hFFFF, 4'b0010});
        do_lit("div_min",   4'd5, 16'h8000, 16'hFFFF, 17, {16'h8000, 16'h0000, 4'b0110});
        do_lit("div_zero",  4'd5, 16'h0064, 16'h0000, 17, {16'hFFFF, 16'h0064, 4'b1010});
        do_lit("illegal",   4'd3, 16'h0001, 16'h0001, 1,  {16'h0000, 16'h0000, 4'b1001});
        do_lit("add_clear", 4'd0, 16'h0002, 16'h0003, 1,  {16'h0005, 16'h0000, 4'b0000});

        // Start while busy is ignored; then back-to-back add from the FIN cycle.
        @(negedge clk);
        opcode = 4'd5; op1 = 16'd1000; op2 = 16'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        opcode = 4'd4; op1 = 16'd3; op2 = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op1 = 16'h1234; op2 = 16'h0011;
        check("ign_busy", busy, 1'b1);
        lat = 6;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", lat, 17);
        check("ign_res", {out, hi, error, ovf, neg, zero}, {16'd142, 16'd6, 4'b0000});
        opcode = 4'd0; op1 = 16'd1; op2 = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_gap", done, 1'b0);
        @(negedge clk);
        check("b2b_done", done, 1'b1);
        check("b2b_res", {out, hi, error, ovf, neg, zero}, {16'd2, 16'd0, 4'b0000});

        // Reset in the middle of a multiply.
        @(negedge clk);
        opcode = 4'd4; op1 = 16'd1234; op2 = 16'd77; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", {busy, done, out, hi, error, ovf, neg, zero}, '0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("rst_no_done", seen, 0);

        // Random traffic, including starts while busy and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            start  = ($urandom_range(0, 2) == 0);
            opcode = rnd_opc();
            op1    = rnd_op();
            op2    = rnd_op();
            @(negedge clk);
        end
        rst = 1'b0; start = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
